// File: rtl/ex_stage_issue_if.sv
// ID -> EX -> MEM handshake bundle plus the EX-side connection to the external ALU.
// master = the surrounding pipeline (ID, ALU, MEM); slave = the EX issue controller.
interface ex_stage_issue_if #(parameter int W = 32);
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_aluop;
   logic [5:0]    in_funct;
   logic [W-1:0]  in_rs_data;
   logic [W-1:0]  in_rt_data;
   logic [W-1:0]  in_imm;
   logic          in_alusrc;
   logic          in_branch;
   logic          in_regwrite;
   logic [4:0]    in_rd;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [3:0]    alu_op;
   logic [W-1:0]  alu_result;
   logic          alu_zero;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic          out_zero;
   logic          out_branch_taken;
   logic          out_regwrite;
   logic [4:0]    out_rd;
   logic          out_illegal;

   modport master (
      output in_valid, in_aluop, in_funct, in_rs_data, in_rt_data, in_imm,
             in_alusrc, in_branch, in_regwrite, in_rd, alu_result, alu_zero, out_ready,
      input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero,
             out_branch_taken, out_regwrite, out_rd, out_illegal
   );

   modport slave (
      input  in_valid, in_aluop, in_funct, in_rs_data, in_rt_data, in_imm,
             in_alusrc, in_branch, in_regwrite, in_rd, alu_result, alu_zero, out_ready,
      output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero,
             out_branch_taken, out_regwrite, out_rd, out_illegal
   );
endinterface

// File: rtl/ex_stage_issue.sv
// Execute-stage issue/retire controller: holds one EX entry feeding the external ALU
// and captures the ALU outcome into an EX/MEM register with valid/ready on both sides.
module ex_stage_issue #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   ex_stage_issue_if.slave bus
);

   // {illegal, alu_op}; unsupported R-type funct falls back to add and is flagged
   function automatic logic [4:0] decode_op(input logic [1:0] aluop, input logic [5:0] funct);
      logic [4:0] r;
      r = 5'b0_0010;
      case (aluop)
         2'b00: r = 5'b0_0010;
         2'b01: r = 5'b0_0110;
         2'b11: r = 5'b0_0001;
         default: begin
            case (funct)
               6'b100000: r = 5'b0_0010;
               6'b100010: r = 5'b0_0110;
               6'b100100: r = 5'b0_0000;
               6'b100101: r = 5'b0_0001;
               6'b101010: r = 5'b0_0111;
               default:   r = 5'b1_0010;
            endcase
         end
      endcase
      return r;
   endfunction

   logic          ex_valid_q, ex_valid_d;
   logic [1:0]    ex_aluop_q, ex_aluop_d;
   logic [5:0]    ex_funct_q, ex_funct_d;
   logic [W-1:0]  ex_rs_q, ex_rs_d;
   logic [W-1:0]  ex_rt_q, ex_rt_d;
   logic [W-1:0]  ex_imm_q, ex_imm_d;
   logic          ex_alusrc_q, ex_alusrc_d;
   logic          ex_branch_q, ex_branch_d;
   logic          ex_regwrite_q, ex_regwrite_d;
   logic [4:0]    ex_rd_q, ex_rd_d;

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_result_q, out_result_d;
   logic          out_zero_q, out_zero_d;
   logic          out_taken_q, out_taken_d;
   logic          out_regwrite_q, out_regwrite_d;
   logic [4:0]    out_rd_q, out_rd_d;
   logic          out_illegal_q, out_illegal_d;

   logic [4:0]    dec;
   logic          advance;
   logic          in_ready;
   logic          xfer;
   logic          retire;

   always_comb begin
      dec      = decode_op(ex_aluop_q, ex_funct_q);
      advance  = !out_valid_q || bus.out_ready;
      in_ready = !flush && (!ex_valid_q || advance);
      xfer     = bus.in_valid && in_ready;
      retire   = ex_valid_q && advance && !flush;
   end

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_aluop_d    = ex_aluop_q;
      ex_funct_d    = ex_funct_q;
      ex_rs_d       = ex_rs_q;
      ex_rt_d       = ex_rt_q;
      ex_imm_d      = ex_imm_q;
      ex_alusrc_d   = ex_alusrc_q;
      ex_branch_d   = ex_branch_q;
      ex_regwrite_d = ex_regwrite_q;
      ex_rd_d       = ex_rd_q;
      // flush forces in_ready low, so a kill never coincides with a load
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (xfer) begin
         ex_valid_d    = 1'b1;
         ex_aluop_d    = bus.in_aluop;
         ex_funct_d    = bus.in_funct;
         ex_rs_d       = bus.in_rs_data;
         ex_rt_d       = bus.in_rt_data;
         ex_imm_d      = bus.in_imm;
         ex_alusrc_d   = bus.in_alusrc;
         ex_branch_d   = bus.in_branch;
         ex_regwrite_d = bus.in_regwrite;
         ex_rd_d       = bus.in_rd;
      end else if (ex_valid_q && advance) begin
         ex_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d    = out_valid_q;
      out_result_d   = out_result_q;
      out_zero_d     = out_zero_q;
      out_taken_d    = out_taken_q;
      out_regwrite_d = out_regwrite_q;
      out_rd_d       = out_rd_q;
      out_illegal_d  = out_illegal_q;
      if (retire) begin
         out_valid_d    = 1'b1;
         out_result_d   = bus.alu_result;
         out_zero_d     = bus.alu_zero;
         out_taken_d    = ex_branch_q && bus.alu_zero;
         out_regwrite_d = ex_regwrite_q && !dec[4];
         out_rd_d       = ex_rd_q;
         out_illegal_d  = dec[4];
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_aluop_q     <= '0;
         ex_funct_q     <= '0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_imm_q       <= '0;
         ex_alusrc_q    <= 1'b0;
         ex_branch_q    <= 1'b0;
         ex_regwrite_q  <= 1'b0;
         ex_rd_q        <= '0;
         out_valid_q    <= 1'b0;
         out_result_q   <= '0;
         out_zero_q     <= 1'b0;
         out_taken_q    <= 1'b0;
         out_regwrite_q <= 1'b0;
         out_rd_q       <= '0;
         out_illegal_q  <= 1'b0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_aluop_q     <= ex_aluop_d;
         ex_funct_q     <= ex_funct_d;
         ex_rs_q        <= ex_rs_d;
         ex_rt_q        <= ex_rt_d;
         ex_imm_q       <= ex_imm_d;
         ex_alusrc_q    <= ex_alusrc_d;
         ex_branch_q    <= ex_branch_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_rd_q        <= ex_rd_d;
         out_valid_q    <= out_valid_d;
         out_result_q   <= out_result_d;
         out_zero_q     <= out_zero_d;
         out_taken_q    <= out_taken_d;
         out_regwrite_q <= out_regwrite_d;
         out_rd_q       <= out_rd_d;
         out_illegal_q  <= out_illegal_d;
      end
   end

   assign bus.in_ready         = in_ready;
   assign bus.alu_a            = ex_rs_q;
   assign bus.alu_b            = ex_alusrc_q ? ex_imm_q : ex_rt_q;
   assign bus.alu_op           = dec[3:0];
   assign bus.out_valid        = out_valid_q;
   assign bus.out_result       = out_result_q;
   assign bus.out_zero         = out_zero_q;
   assign bus.out_branch_taken = out_taken_q;
   assign bus.out_regwrite     = out_regwrite_q;
   assign bus.out_rd           = out_rd_q;
   assign bus.out_illegal      = out_illegal_q;

endmodule

// File: doc/ex_stage_issue.md
Name: ex_stage_issue

Overview:
- Execute-stage issue/retire controller for the single-cycle-to-pipelined datapath rework.
- Accepts decoded instructions from ID and decodes ALUOp/funct into the 4-bit ALU operation code.
- Drives the external combinational ALU's a/b/operation inputs and captures its result/zero into an EX/MEM output register.
- Uses valid/ready handshakes on both sides and supports flush for branch redirect.

Parameters:
- W, 32, datapath width of operands and result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of the EX-stage entry and of any same-cycle input beat.
- in_valid  input  1  ID presents an instruction.
- in_ready  output  1  EX can accept this cycle.
- in_aluop  input  2  ALUOp from main control.
- in_funct  input  6  instruction funct field.
- in_rs_data  input  W  first operand.
- in_rt_data  input  W  second register operand.
- in_imm  input  W  already-extended immediate.
- in_alusrc  input  1  1 selects in_imm as operand b.
- in_branch  input  1  instruction is beq.
- in_regwrite  input  1  writes register file.
- in_rd  input  5  destination register.
- alu_a  output  W  to ALU a.
- alu_b  output  W  to ALU b.
- alu_op  output  4  to ALU operation.
- alu_result  input  W  from ALU.
- alu_zero  input  1  from ALU; 1 when a==b, independent of operation.
- out_valid  output  1  EX/MEM entry valid.
- out_ready  input  1  MEM consumes the entry.
- out_result  output  W  captured ALU result.
- out_zero  output  1  captured alu_zero.
- out_branch_taken  output  1  in_branch & zero of the retired instruction.
- out_regwrite  output  1  forwarded control; forced 0 when out_illegal.
- out_rd  output  5  forwarded destination.
- out_illegal  output  1  unsupported funct under ALUOp 10.

Behaviour:
- Two registered stages: EX register (ex_valid plus captured inputs) and output register.
- alu_a = EX rs_data; alu_b = EX alusrc ? imm : rt_data; alu_op decoded combinationally from EX aluop/funct.
- Decode:
  - aluop 00 -> 0010 (add).
  - aluop 01 -> 0110 (sub).
  - aluop 11 -> 0001 (or).
  - aluop 10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
  - Any other funct under 10 -> 0010 with illegal=1.
- advance = !out_valid | out_ready.
- in_ready = !flush & (!ex_valid | advance). Combinational; must not depend on in_valid.
- Input transfer on in_valid & in_ready: EX register loads all in_* fields and ex_valid <= 1.
- Retire on ex_valid & advance & !flush:
  - Output register loads alu_result, alu_zero, in_branch & alu_zero, regwrite & !illegal, rd, illegal.
  - out_valid <= 1.
- EX clears: if ex_valid & advance and no new transfer occurs, ex_valid <= 0.
- Output drains: if out_valid & out_ready and no retire occurs, out_valid <= 0.
- Latency: input transfer at edge N -> out_valid at edge N+1 when unstalled. Sustained throughput is 1 per cycle.
- Backpressure: with out_ready=0 and out_valid=1, the EX entry holds, alu_* outputs stay stable, and in_ready=0. No entry is lost or duplicated.
- Flush: ex_valid <= 0 and the same-cycle input beat is dropped (in_ready=0). The output register is unaffected because its entry is already committed.
- Reset (async, any time including mid-stall):
  - ex_valid=0, out_valid=0.
  - All captured fields 0, so alu_a=0, alu_b=0, alu_op=0010.
  - out_result=0, out_zero=0, out_branch_taken=0, out_regwrite=0, out_rd=0, out_illegal=0.
- Output fields change only on retire edges. Held values persist while out_valid=0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, alu_op=0010, all out_* =0 immediately (async).
- R-type sequence with out_ready=1: sub (aluop 10, funct 100010), rs=7, rt=10 -> alu_op=0110; next cycle out_result=0xFFFFFFFD, out_zero=0. Then back-to-back slt with rs=3, rt=5 -> out_result=1 one cycle later; one result per cycle.
- beq (aluop 01, branch=1) with rs=rt=0x1234 -> out_branch_taken=1, out_zero=1, out_regwrite=0. With rt=0x1235 -> out_branch_taken=0.
- I-type ori (aluop 11, alusrc=1, imm=0x00F0, rs=0x0F00) -> alu_b=0x00F0, out_result=0x0FF0.
- Backpressure: hold out_ready=0 for 3 cycles with 3 instructions offered -> in_ready=0 after the EX register fills, alu_* stable. Release -> results emerge in order, none dropped.
- Flush and illegal:
  - flush=1 while ex_valid=1 and in_valid=1 -> neither instruction retires; the out entry is preserved.
  - funct 000111 under aluop 10 -> out_illegal=1, out_regwrite=0, alu_op=0010.
